// File: rtl/cursor_input_controller.sv
// rtl/cursor_input_controller.sv - synchronise/debounce board buttons and rotary, drive cursor and enter
module cursor_input_controller #(
    parameter int DEBOUNCE_CYCLES   = 500000,
    parameter int ROT_FILTER_CYCLES = 1000
) (
    input  logic       Clock,
    input  logic       Reset,
    input  logic       BTN_NORTH,
    input  logic       BTN_SOUTH,
    input  logic       BTN_EAST,
    input  logic       BTN_WEST,
    input  logic       ROT_CENTER,
    input  logic       ROT_A,
    input  logic       ROT_B,
    output logic [3:0] oCeldaSelect,
    output logic       oSelect,
    output logic       oEnter,
    output logic [3:0] oEnterCelda,
    output logic       oMoved
);

    localparam int NMAX = (DEBOUNCE_CYCLES > ROT_FILTER_CYCLES) ? DEBOUNCE_CYCLES : ROT_FILTER_CYCLES;
    localparam int CW   = (NMAX > 1) ? $clog2(NMAX) : 1;
    localparam logic [CW-1:0] LIM_BTN = CW'(DEBOUNCE_CYCLES - 1);
    localparam logic [CW-1:0] LIM_ROT = CW'(ROT_FILTER_CYCLES - 1);

    // bit order: 0 north, 1 south, 2 east, 3 west, 4 center, 5 rot_a, 6 rot_b
    logic [6:0]    raw;
    logic [6:0]    meta_q;
    logic [6:0]    sync_q;
    logic [6:0]    deb_q;
    logic [6:0]    deb_prev_q;
    logic [6:0]    block_q;
    logic [CW-1:0] cnt_q [7];
    logic [1:0]    fill_q;
    logic          fill_done;
    logic [6:0]    rise;

    logic [3:0]    cursor_q, cursor_d;
    logic          moved_q, moved_d;
    logic          enter_q;
    logic [3:0]    enter_celda_q;
    logic          select_q;
    logic [1:0]    row, col;

    assign raw       = {ROT_B, ROT_A, ROT_CENTER, BTN_WEST, BTN_EAST, BTN_SOUTH, BTN_NORTH};
    assign fill_done = (fill_q == 2'd2);
    // A level held through reset stays blocked until it is seen released, so no press is invented.
    assign rise      = deb_q & ~deb_prev_q & ~block_q;
    assign row       = cursor_q[3:2];
    assign col       = cursor_q[1:0];

    always_ff @(posedge Clock) begin
        if (!Reset) begin
            meta_q     <= '0;
            sync_q     <= '0;
            deb_q      <= '0;
            deb_prev_q <= '0;
            block_q    <= block_q | sync_q | deb_q;
            fill_q     <= '0;
            for (int i = 0; i < 7; i++) begin
                cnt_q[i] <= '0;
            end
        end else begin
            meta_q     <= raw;
            sync_q     <= meta_q;
            deb_prev_q <= deb_q;
            block_q    <= block_q & ~({7{fill_done}} & ~sync_q & ~deb_q);
            if (!fill_done) begin
                fill_q <= fill_q + 2'd1;
            end
            for (int i = 0; i < 7; i++) begin
                if (sync_q[i] == deb_q[i]) begin
                    cnt_q[i] <= '0;
                end else if (cnt_q[i] == ((i >= 5) ? LIM_ROT : LIM_BTN)) begin
                    deb_q[i] <= sync_q[i];
                    cnt_q[i] <= '0;
                end else begin
                    cnt_q[i] <= cnt_q[i] + 1'b1;
                end
            end
        end
    end

    // Priority: north > south > east > west > rotary; losers are dropped.
    always_comb begin
        cursor_d = cursor_q;
        moved_d  = 1'b1;
        if (rise[0]) begin
            cursor_d = {row - 2'd1, col};
        end else if (rise[1]) begin
            cursor_d = {row + 2'd1, col};
        end else if (rise[2]) begin
            cursor_d = {row, col - 2'd1};
        end else if (rise[3]) begin
            cursor_d = {row, col + 2'd1};
        end else if (rise[5]) begin
            cursor_d = deb_q[6] ? (cursor_q - 4'd1) : (cursor_q + 4'd1);
        end else begin
            moved_d = 1'b0;
        end
    end

    always_ff @(posedge Clock) begin
        if (!Reset) begin
            cursor_q      <= '0;
            moved_q       <= 1'b0;
            enter_q       <= 1'b0;
            enter_celda_q <= '0;
            select_q      <= 1'b0;
        end else begin
            cursor_q <= cursor_d;
            moved_q  <= moved_d;
            enter_q  <= rise[4];
            select_q <= 1'b1;
            if (rise[4]) begin
                enter_celda_q <= cursor_q;
            end
        end
    end

    assign oCeldaSelect = cursor_q;
    assign oSelect      = select_q;
    assign oEnter       = enter_q;
    assign oEnterCelda  = enter_celda_q;
    assign oMoved       = moved_q;

endmodule

// File: tb/tb_cursor_input_controller.sv
// tb/tb_cursor_input_controller.sv - directed and randomized bench for cursor_input_controller
module tb_cursor_input_controller;

    logic       clk = 1'b0;
    logic       rstn;
    logic       btn_n, btn_s, btn_e, btn_w, rot_c, rot_a, rot_b;
    logic [3:0] celda, enter_celda;
    logic       sel, enter, moved;

    int total = 0;
    int passed = 0;
    int moved_cnt = 0;
    int enter_cnt = 0;
    int model_idx;

    localparam logic [6:0] MN = 7'h01, MS = 7'h02, ME = 7'h04, MW = 7'h08;
    localparam logic [6:0] MC = 7'h10, MA = 7'h20, MB = 7'h40;

    cursor_input_controller #(.DEBOUNCE_CYCLES(4), .ROT_FILTER_CYCLES(2)) dut (
        .Clock(clk), .Reset(rstn),
        .BTN_NORTH(btn_n), .BTN_SOUTH(btn_s), .BTN_EAST(btn_e), .BTN_WEST(btn_w),
        .ROT_CENTER(rot_c), .ROT_A(rot_a), .ROT_B(rot_b),
        .oCeldaSelect(celda), .oSelect(sel), .oEnter(enter),
        .oEnterCelda(enter_celda), .oMoved(moved)
    );

    always #5 clk = ~clk;

    always @(negedge clk) begin
        if (moved) moved_cnt <= moved_cnt + 1;
        if (enter) enter_cnt <= enter_cnt + 1;
    end

    task automatic check(input string tag, input int obs, input int exp);
        total++;
        assert (obs === exp) passed++;
        else $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    endtask

    task automatic ticks(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic drive(input logic [6:0] m);
        btn_n = m[0]; btn_s = m[1]; btn_e = m[2]; btn_w = m[3];
        rot_c = m[4]; rot_a = m[5]; rot_b = m[6];
    endtask

    task automatic press(input logic [6:0] m);
        drive(m);
        ticks(10);
        drive(7'h00);
        ticks(10);
    endtask

    task automatic rotate(input bit ccw);
        logic [6:0] b;
        b = ccw ? MB : 7'h00;
        drive(b);      ticks(6);
        drive(b | MA); ticks(6);
        drive(b);      ticks(6);
        drive(7'h00);  ticks(6);
    endtask

    // dir: 0 north, 1 south, 2 east, 3 west, 4 clockwise, 5 counter-clockwise
    function automatic int model_move(input int idx, input int dir);
        int r, c;
        r = idx / 4;
        c = idx % 4;
        case (dir)
            0: r = (r + 3) % 4;
            1: r = (r + 1) % 4;
            2: c = (c + 3) % 4;
            3: c = (c + 1) % 4;
            4: return (idx + 1) % 16;
            default: return (idx + 15) % 16;
        endcase
        return r * 4 + c;
    endfunction

    function automatic logic [6:0] dir_mask(input int dir);
        case (dir)
            0: return MN;
            1: return MS;
            2: return ME;
            default: return MW;
        endcase
    endfunction

    initial begin
        int m0, e0, op, i, j, g;

        drive(7'h00);
        rstn = 1'b0;
        ticks(3);
        check("rst_celda", celda, 0);
        check("rst_select", sel, 0);
        check("rst_enter", enter, 0);
        check("rst_enter_celda", enter_celda, 0);
        check("rst_moved", moved, 0);

        rstn = 1'b1;
        drive(MS);
        ticks(1);
        check("t1_select", sel, 1);
        check("t1_celda_e1", celda, 0);
        ticks(5);
        check("t1_celda_e6", celda, 0);
        check("t1_moved_e6", moved, 0);
        ticks(1);
        check("t1_celda_e7", celda, 4);
        check("t1_moved_e7", moved, 1);
        ticks(1);
        check("t1_moved_e8", moved, 0);
        drive(7'h00);
        ticks(10);
        model_idx = 4;

        m0 = moved_cnt;
        drive(MW); ticks(3); drive(7'h00); ticks(15);
        check("t2_glitch_celda", celda, model_idx);
        check("t2_glitch_moved", moved_cnt - m0, 0);
        drive(MW); ticks(10); drive(7'h00); ticks(10);
        model_idx = model_move(model_idx, 3);
        check("t2_hold_celda", celda, model_idx);
        for (int k = 0; k < 3; k++) begin
            press(MW);
            model_idx = model_move(model_idx, 3);
        end
        check("t2_col_wrap", celda, model_idx);
        check("t2_col_zero", celda % 4, 0);

        press(MN); model_idx = model_move(model_idx, 0);
        check("t3_at_zero", celda, 0);
        press(MN); model_idx = model_move(model_idx, 0);
        check("t3_north_wrap", celda, 12);
        press(ME); model_idx = model_move(model_idx, 2);
        check("t3_east_wrap", celda, 15);
        rotate(1'b0); model_idx = model_move(model_idx, 4);
        check("t3_cw_wrap", celda, 0);
        rotate(1'b1); model_idx = model_move(model_idx, 5);
        check("t3_ccw_wrap", celda, 15);
        check("t3_model", celda, model_idx);

        rotate(1'b0);
        press(MS);
        press(MW);
        model_idx = 5;
        check("t4_at_five", celda, 5);
        m0 = moved_cnt;
        drive(MN | MW); ticks(10);
        check("t4_priority", celda, 1);
        drive(7'h00); ticks(20);
        check("t4_no_more", celda, 1);
        check("t4_moved_once", moved_cnt - m0, 1);
        model_idx = 1;

        press(MS);
        press(MS);
        check("t5_at_nine", celda, 9);
        drive(MS | MC);
        ticks(6);
        check("t5_enter_e6", enter, 0);
        ticks(1);
        check("t5_enter_e7", enter, 1);
        check("t5_enter_celda", enter_celda, 9);
        check("t5_celda_moved", celda, 13);
        ticks(1);
        check("t5_enter_e8", enter, 0);
        drive(7'h00); ticks(10);
        e0 = enter_cnt;
        drive(MC); ticks(100); drive(7'h00); ticks(10);
        check("t5_one_enter", enter_cnt - e0, 1);
        check("t5_enter_celda2", enter_celda, 13);
        model_idx = 13;

        drive(MS);
        ticks(6);
        rstn = 1'b0;
        ticks(1);
        check("t6_rst_celda", celda, 0);
        check("t6_rst_select", sel, 0);
        rstn = 1'b1;
        m0 = moved_cnt;
        e0 = enter_cnt;
        ticks(20);
        check("t6_held_celda", celda, 0);
        check("t6_held_moved", moved_cnt - m0, 0);
        drive(7'h00); ticks(10);
        press(MS);
        check("t6_repress", celda, 4);
        model_idx = 4;

        for (int n = 0; n < 40; n++) begin
            if ($urandom_range(0, 3) == 0) begin
                g = $urandom_range(0, 3);
                m0 = moved_cnt;
                drive(dir_mask(g)); ticks($urandom_range(1, 3)); drive(7'h00); ticks(8);
                check("rnd_glitch", moved_cnt - m0, 0);
            end
            op = $urandom_range(0, 7);
            m0 = moved_cnt;
            e0 = enter_cnt;
            if (op <= 3) begin
                press(dir_mask(op));
                model_idx = model_move(model_idx, op);
            end else if (op == 4 || op == 5) begin
                rotate(op == 5);
                model_idx = model_move(model_idx, op);
            end else if (op == 6) begin
                press(MC);
                check("rnd_enter_celda", enter_celda, model_idx);
            end else begin
                i = $urandom_range(0, 3);
                j = (i + 1 + $urandom_range(0, 2)) % 4;
                press(dir_mask(i) | dir_mask(j));
                model_idx = model_move(model_idx, (i < j) ? i : j);
            end
            check("rnd_celda", celda, model_idx);
            check("rnd_moved", moved_cnt - m0, (op == 6) ? 0 : 1);
            check("rnd_enter", enter_cnt - e0, (op == 6) ? 1 : 0);
        end

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
